// File: rtl/forwarding_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_unit_pkg
//  Description : Shared widths and pipeline record types for forwarding.
//  Revision    : 1.0 - initial release
// ============================================================================
package forwarding_unit_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     we;
        logic     is_load;
    } ex_rec_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
        logic     is_load;
        xword_t   alu_result;
    } mem_rec_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     we;
        xword_t   value;
    } wb_rec_t;

    // x0 is hardwired zero, so a record never produces it
    function automatic logic produces(input logic valid, input logic we,
                                      input reg_idx_t rd, input reg_idx_t r);
        return valid & we & (rd == r) & (r != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : Per-operand forwarding match with MEM-over-WB priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
    import forwarding_unit_pkg::*;
(
    input  logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] src,
    input  mem_rec_t             mem_rec,
    input  wb_rec_t              wb_rec,
    output logic                 fwd,
    output logic [XLEN-1:0]      sel,
    output logic                 mem_load_hit
);

    logic w_mem_prod;
    logic w_mem_hit;
    logic w_wb_hit;

    always_comb begin
        w_mem_prod   = produces(mem_rec.valid, mem_rec.we, mem_rec.rd, src);
        // a load in MEM has no data yet; only ALU results forward from MEM
        w_mem_hit    = ex_valid & w_mem_prod & ~mem_rec.is_load;
        w_wb_hit     = ex_valid & produces(wb_rec.valid, wb_rec.we, wb_rec.rd, src);
        mem_load_hit = ex_valid & w_mem_prod & mem_rec.is_load;
        fwd          = w_mem_hit | w_wb_hit;
        if (w_mem_hit) begin
            sel = mem_rec.alu_result;
        end else if (w_wb_hit) begin
            sel = wb_rec.value;
        end else begin
            sel = '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module      : forwarding_unit
//  Description : EX/MEM/WB record tracking, operand forwarding, load-use stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module forwarding_unit
    import forwarding_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 id_valid,
    input  logic                 id_we,
    input  logic                 id_is_load,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    input  logic [XLEN-1:0]      ex_alu_result,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 forward_a,
    output logic                 forward_b,
    output logic [XLEN-1:0]      rs1_sel,
    output logic [XLEN-1:0]      rs2_sel,
    output logic                 load_use_stall_o
);

    ex_rec_t  r_ex;
    mem_rec_t r_mem;
    wb_rec_t  r_wb;

    logic            w_load_use_stall;
    logic            w_fwd_a;
    logic            w_fwd_b;
    logic [XLEN-1:0] w_sel_a;
    logic [XLEN-1:0] w_sel_b;
    logic            w_mem_load_hit_a;
    logic            w_mem_load_hit_b;

    assign w_load_use_stall = id_valid & r_ex.valid & r_ex.is_load & r_ex.we
                            & (r_ex.rd != '0)
                            & ((r_ex.rd == id_rs1) | (r_ex.rd == id_rs2));

    fwd_select u_fwd_rs1 (
        .ex_valid     (r_ex.valid),
        .src          (r_ex.rs1),
        .mem_rec      (r_mem),
        .wb_rec       (r_wb),
        .fwd          (w_fwd_a),
        .sel          (w_sel_a),
        .mem_load_hit (w_mem_load_hit_a)
    );

    fwd_select u_fwd_rs2 (
        .ex_valid     (r_ex.valid),
        .src          (r_ex.rs2),
        .mem_rec      (r_mem),
        .wb_rec       (r_wb),
        .fwd          (w_fwd_b),
        .sel          (w_sel_b),
        .mem_load_hit (w_mem_load_hit_b)
    );

    // Outputs are forced quiet while reset is held, not only after the edge
    assign forward_a        = rstn & w_fwd_a;
    assign forward_b        = rstn & w_fwd_b;
    assign rs1_sel          = {XLEN{rstn}} & w_sel_a;
    assign rs2_sel          = {XLEN{rstn}} & w_sel_b;
    assign load_use_stall_o = rstn & w_load_use_stall;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!stall_i) begin
            r_wb.valid       <= r_mem.valid;
            r_wb.rd          <= r_mem.rd;
            r_wb.we          <= r_mem.we;
            r_wb.value       <= r_mem.is_load ? mem_rdata : r_mem.alu_result;
            r_mem.valid      <= r_ex.valid;
            r_mem.rd         <= r_ex.rd;
            r_mem.we         <= r_ex.we;
            r_mem.is_load    <= r_ex.is_load;
            r_mem.alu_result <= ex_alu_result;
            r_ex.valid       <= id_valid & ~flush_i & ~w_load_use_stall;
            r_ex.rs1         <= id_rs1;
            r_ex.rs2         <= id_rs2;
            r_ex.rd          <= id_rd;
            r_ex.we          <= id_we;
            r_ex.is_load     <= id_is_load;
        end
    end

    // The load-use stall must keep a MEM-stage load from ever meeting a consumer
    a_no_mem_load_fwd: assert property (@(posedge clk) disable iff (!rstn)
        !(w_mem_load_hit_a | w_mem_load_hit_b));

endmodule
`default_nettype wire

// File: tb/tb_forwarding_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_forwarding_unit
//  Description : Directed self-checking bench for forwarding_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_unit;

    localparam logic [63:0] c_junk = 64'hBAD0_BAD0_BAD0_BAD0;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stall_i;
    logic        flush_i;
    logic        id_valid;
    logic        id_we;
    logic        id_is_load;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [63:0] ex_alu_result;
    logic [63:0] mem_rdata;
    logic        forward_a;
    logic        forward_b;
    logic [63:0] rs1_sel;
    logic [63:0] rs2_sel;
    logic        load_use_stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    forwarding_unit dut (
        .clk              (clk),
        .rstn             (rstn),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .id_valid         (id_valid),
        .id_we            (id_we),
        .id_is_load       (id_is_load),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rd            (id_rd),
        .ex_alu_result    (ex_alu_result),
        .mem_rdata        (mem_rdata),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .rs1_sel          (rs1_sel),
        .rs2_sel          (rs2_sel),
        .load_use_stall_o (load_use_stall_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic fa, input logic fb,
                             input logic [63:0] s1, input logic [63:0] s2, input logic st);
        check_eq({tag, ".forward_a"}, {63'd0, forward_a}, {63'd0, fa});
        check_eq({tag, ".forward_b"}, {63'd0, forward_b}, {63'd0, fb});
        check_eq({tag, ".rs1_sel"}, rs1_sel, s1);
        check_eq({tag, ".rs2_sel"}, rs2_sel, s2);
        check_eq({tag, ".stall"}, {63'd0, load_use_stall_o}, {63'd0, st});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic we, input logic ld,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_valid   = v;
        id_we      = we;
        id_is_load = ld;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_rd      = rd;
    endtask

    task automatic drain();
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        ex_alu_result = 64'd0;
        mem_rdata     = c_junk;
        repeat (3) tick();
    endtask

    initial begin
        rstn = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        ex_alu_result = 64'd0; mem_rdata = c_junk;
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd5);
        tick(); tick();
        check_all("reset", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        rstn = 1'b1;
        set_id(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        #1 check_all("post_reset", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        tick();

        // addi x5=7 ; add x6,x5,x5
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5); tick();
        ex_alu_result = 64'd7;
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 5'd6); tick();
        check_all("addi_add", 1'b1, 1'b1, 64'd7, 64'd7, 1'b0);
        drain();

        // x5=7, x5=9, consumer of x5: MEM beats WB; then WB-only forward on rs2
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5); tick();
        ex_alu_result = 64'd7;
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd5); tick();
        ex_alu_result = 64'd9;
        set_id(1'b1, 1'b0, 1'b0, 5'd5, 5'd3, 5'd0); tick();
        check_all("mem_prio", 1'b1, 1'b0, 64'd9, 64'd0, 1'b0);
        ex_alu_result = 64'h4242;
        set_id(1'b1, 1'b1, 1'b0, 5'd3, 5'd5, 5'd8); tick();
        check_all("wb_only", 1'b0, 1'b1, 64'd0, 64'd9, 1'b0);
        drain();

        // ld x5 ; add x6,x5,x0
        set_id(1'b1, 1'b1, 1'b1, 5'd2, 5'd0, 5'd5); tick();
        set_id(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 5'd6);
        ex_alu_result = 64'h100;
        #1 check_eq("load_use.stall", {63'd0, load_use_stall_o}, 64'd1);
        tick();
        mem_rdata = 64'hDEAD_BEEF;
        check_all("load_use.bubble", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        tick();
        mem_rdata = c_junk;
        check_all("load_use.wb_fwd", 1'b1, 1'b0, 64'hDEAD_BEEF, 64'd0, 1'b0);
        drain();

        // writes to x0 are never forwarded
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); tick();
        ex_alu_result = 64'd5;
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd6); tick();
        check_all("x0_mem", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        ex_alu_result = 64'd1;
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7); tick();
        check_all("x0_wb", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drain();

        // stall holds everything, even with flush; then flush kills ID
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd7); tick();
        ex_alu_result = 64'h77;
        set_id(1'b1, 1'b1, 1'b0, 5'd7, 5'd7, 5'd8); tick();
        check_all("pre_stall", 1'b1, 1'b1, 64'h77, 64'h77, 1'b0);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
            ex_alu_result = 64'h1234 + 64'(i);
            mem_rdata     = 64'h5555 + 64'(i);
            flush_i       = (i == 1);
            tick();
            check_all("stall_hold", 1'b1, 1'b1, 64'h77, 64'h77, 1'b0);
        end
        stall_i = 1'b0;
        mem_rdata = c_junk;
        set_id(1'b1, 1'b1, 1'b0, 5'd7, 5'd0, 5'd9);
        flush_i = 1'b1;
        ex_alu_result = 64'h88;
        tick();
        flush_i = 1'b0;
        check_all("flush", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        drain();

        // reset mid-sequence while stalled
        set_id(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd9); tick();
        ex_alu_result = 64'h99;
        set_id(1'b1, 1'b1, 1'b0, 5'd9, 5'd9, 5'd10); tick();
        check_eq("pre_rst.forward_a", {63'd0, forward_a}, 64'd1);
        stall_i = 1'b1;
        rstn = 1'b0;
        #1 check_all("in_rst", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        tick();
        check_all("after_rst", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        rstn = 1'b1;
        stall_i = 1'b0;
        ex_alu_result = 64'h55;
        tick();
        check_all("rst_no_stale1", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);
        tick();
        check_all("rst_no_stale2", 1'b0, 1'b0, 64'd0, 64'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forwarding_unit.md
FORWARDING_UNIT -- requirements
Module: forwarding_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset: clk (rising edge) and rstn; rstn=0 sampled at a clk edge resets the block.
REQ-002 clk  in  1  pipeline clock.
REQ-003 rstn  in  1  synchronous active-low reset.
REQ-004 stall_i  in  1  global pipeline freeze (memory wait); all records hold.
REQ-005 flush_i  in  1  kill the instruction leaving ID (taken branch resolved in EX).
REQ-006 id_valid, id_we, id_is_load  in  1 each  instruction in ID is valid / writes rd / is a load.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  register indices of the ID instruction.
REQ-008 ex_alu_result  in  64  result of the instruction currently in EX.
REQ-009 mem_rdata  in  64  load data of the instruction currently in MEM, valid in the same cycle.
REQ-010 forward_a, forward_b  out  1 each  replace rs1/rs2 read data of the EX instruction.
REQ-011 rs1_sel, rs2_sel  out  64 each  forwarded operand values for the EX instruction.
REQ-012 load_use_stall_o  out  1  hold IF/ID one cycle and insert a bubble into EX.

Function
REQ-013 Three in-flight records SHALL be kept: EX {valid, rs1, rs2, rd, we, is_load}, MEM {valid, rd, we, is_load, alu_result}, WB {valid, rd, we, value}.
REQ-014 Advance occurs on a clk edge when stall_i=0; when stall_i=1 all records SHALL hold unchanged.
REQ-015 On advance: WB <- MEM with WB.value = MEM.is_load ? mem_rdata : MEM.alu_result; MEM <- EX with MEM.alu_result = ex_alu_result; EX <- ID fields with EX.valid = id_valid & ~flush_i & ~load_use_stall_o.
REQ-016 load_use_stall_o SHALL be combinational: id_valid & EX.valid & EX.is_load & EX.we & (EX.rd != 0) & (EX.rd == id_rs1 | EX.rd == id_rs2).
REQ-017 A record "produces r" iff valid & we & rd == r & r != 0; x0 SHALL never be forwarded.
REQ-018 forward_a SHALL be 1 iff MEM produces EX.rs1 with MEM.is_load=0, or WB produces EX.rs1; rs1_sel = MEM.alu_result if MEM matches, else WB.value (MEM has priority over WB).
REQ-019 forward_b/rs2_sel SHALL follow REQ-018 with EX.rs2.
REQ-020 Forwarding outputs SHALL be 0 / 64'h0 when EX.valid=0 or no match; all outputs are combinational from records (zero-cycle latency).
REQ-021 A MEM-stage load matching an EX source SHALL NOT be forwarded from MEM; it is unreachable by REQ-016, and a simulation-only assertion SHALL flag it.
REQ-022 flush_i and load_use_stall_o together: EX receives a bubble; stall_i overrides both (no record change).
REQ-023 flush_i SHALL NOT affect MEM or WB records.

Reset
REQ-024 On rstn=0: all record valid bits and fields SHALL clear to 0; rstn has priority over stall_i and flush_i.
REQ-025 During and one cycle after reset all outputs SHALL be 0 (records empty).

Structure
REQ-026 A shared package SHALL define the record struct types (ex_rec_t, mem_rec_t, wb_rec_t), XLEN=64 and REG_IDX_W=5.
REQ-027 One sub-module fwd_select SHALL implement the per-operand match/priority (instanced twice for rs1 and rs2); record registers stay in forwarding_unit.

Verification
REQ-028 addi x5=7 then add x6,x5,x5: with the add in EX, forward_a=forward_b=1 and rs1_sel=rs2_sel=7 from MEM.
REQ-029 Producer x5=7 and then x5=9 two and one ahead of a consumer of x5: rs1_sel=9 (MEM priority over WB).
REQ-030 ld x5 then add x6,x5,x0: load_use_stall_o=1 for one cycle, bubble in EX; next cycles forward_a=1 from WB with rs1_sel=mem_rdata (0xDEAD_BEEF).
REQ-031 Producer writes x0=5 and consumer reads x0: forward_a=0 and rs1_sel=0.
REQ-032 stall_i=1 for 3 cycles mid-sequence: forward_*/rs*_sel are held constant; flush_i with id_valid=1 yields EX.valid=0 next cycle.
REQ-033 rstn=0 asserted mid-sequence with stall_i=1: all outputs are 0 after the edge, and no stale forwarding occurs afterwards.
